// File: rtl/candidate_bank_arbiter_pkg.sv
// Shared constants, state/grant encodings and the word-address to byte-index
// mapping for the candidate bank arbiter.
package candidate_bank_arbiter_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int NUM_WORDS  = 16;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    // Word n occupies bytes 2n (high) and 2n+1 (low).
    function automatic logic [WORD_WIDTH-1:0] addr_to_index(input logic [ADDR_WIDTH-1:0] addr);
        return {{(WORD_WIDTH-ADDR_WIDTH-1){1'b0}}, addr, 1'b0};
    endfunction

endpackage

// File: rtl/candidate_bank_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; under contention the requester that was
// not granted last wins, so a loser waits at most one granted cycle.
module rr_arbiter2
    import candidate_bank_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    grant_t last_grant_q;

    always_comb begin
        gnt_wr = en && req_wr && (!req_rd || (last_grant_q == GNT_RD));
        gnt_rd = en && req_rd && (!req_wr || (last_grant_q == GNT_WR));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_RD;
        end else if (gnt_wr) begin
            last_grant_q <= GNT_WR;
        end else if (gnt_rd) begin
            last_grant_q <= GNT_RD;
        end
    end

endmodule

// File: rtl/candidate_bank_arbiter.sv
// Shares one byte-organised candidate bank between a writer and a reader, and
// runs a full-bank clear sweep on request.
module candidate_bank_arbiter
    import candidate_bank_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_index,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out
);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [WORD_WIDTH-1:0]   idx_q;
    logic [WORD_WIDTH-1:0]   rd_data_p1;
    logic                    vld_p1;
    logic                    clr_done_p1;
    logic                    arb_en;
    logic                    gnt_wr;
    logic                    gnt_rd;
    logic                    clr_last;

    // Grants are suppressed while in reset, during the sweep and in the clr_start cycle.
    assign arb_en   = !rst && (state_q == ST_IDLE) && !clr_start;
    assign clr_last = (state_q == ST_CLEAR) && (clr_cnt_q == ADDR_WIDTH'(NUM_WORDS-1));

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req_wr (wr_valid),
        .req_rd (rd_valid),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        mem_wr_en   = 1'b0;
        mem_index   = idx_q;
        mem_data_in = '0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (gnt_wr) begin
                    mem_wr_en   = 1'b1;
                    mem_index   = addr_to_index(wr_addr);
                    mem_data_in = wr_data;
                end else if (gnt_rd) begin
                    mem_index = addr_to_index(rd_addr);
                end
            end
            ST_CLEAR: begin
                mem_wr_en = 1'b1;
                mem_index = addr_to_index(clr_cnt_q);
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            idx_q     <= mem_index;
        end
    end

    // Stage p0 -> p1: capture bank read data and the end-of-sweep pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1  <= '0;
            vld_p1      <= 1'b0;
            clr_done_p1 <= 1'b0;
        end else begin
            if (gnt_rd) begin
                rd_data_p1 <= mem_data_out;
            end
            vld_p1      <= gnt_rd;
            clr_done_p1 <= clr_last;
        end
    end

    assign wr_ready      = gnt_wr;
    assign rd_ready      = gnt_rd;
    assign rd_data       = rd_data_p1;
    assign rd_data_valid = vld_p1;
    assign clr_busy      = (state_q == ST_CLEAR);
    assign clr_done      = clr_done_p1;

endmodule

// File: tb/tb_candidate_bank_arbiter.sv
// Directed bench for candidate_bank_arbiter with a big-endian 32-byte bank model.
module tb_candidate_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [3:0]  rd_addr;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic        mem_wr_en;
    logic [15:0] mem_index;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    logic [7:0]  bank [0:31];
    logic        bank_init = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    candidate_bank_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .clr_done      (clr_done),
        .mem_wr_en     (mem_wr_en),
        .mem_index     (mem_index),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out)
    );

    always #5 clk = ~clk;

    // Bank model: power-on contents byte i = 0xA0+i, so word 5 reads 0xAAAB.
    always @(posedge clk) begin
        if (!bank_init) begin
            for (int i = 0; i < 32; i++) bank[i] <= 8'(8'hA0 + i);
            bank_init <= 1'b1;
        end else if (mem_wr_en && mem_index < 16'd31) begin
            bank[mem_index[4:0]]        <= mem_data_in[15:8];
            bank[mem_index[4:0] + 5'd1] <= mem_data_in[7:0];
        end
    end

    always_comb begin
        mem_data_out = 16'h0000;
        if (mem_index < 16'd31)
            mem_data_out = {bank[mem_index[4:0]], bank[mem_index[4:0] + 5'd1]};
    end

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                         input logic rv, input logic [3:0] ra, input logic cs);
        @(negedge clk);
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        clr_start = cs;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        drive(1'b1, a, d, 1'b0, 4'd0, 1'b0);
        check_eq("wr_ready", 16'(wr_ready), 16'd1);
        check_eq("wr_mem_wr_en", 16'(mem_wr_en), 16'd1);
        check_eq("wr_index", mem_index, {11'd0, a, 1'b0});
        check_eq("wr_data_in", mem_data_in, d);
    endtask

    task automatic read_word(input logic [3:0] a, input logic [15:0] exp);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, a, 1'b0);
        check_eq("rd_ready", 16'(rd_ready), 16'd1);
        check_eq("rd_index", mem_index, {11'd0, a, 1'b0});
        check_eq("rd_mem_wr_en", 16'(mem_wr_en), 16'd0);
        idle();
        check_eq("rd_valid", 16'(rd_data_valid), 16'd1);
        check_eq("rd_data", rd_data, exp);
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
        rd_valid = 1'b1; rd_addr = 4'd4; clr_start = 1'b0;
        #2;
        check_eq("rst_rd_data", rd_data, 16'h0000);
        check_eq("rst_rd_valid", 16'(rd_data_valid), 16'd0);
        check_eq("rst_clr_busy", 16'(clr_busy), 16'd0);
        check_eq("rst_clr_done", 16'(clr_done), 16'd0);
        check_eq("rst_mem_wr_en", 16'(mem_wr_en), 16'd0);
        check_eq("rst_wr_ready", 16'(wr_ready), 16'd0);
        check_eq("rst_rd_ready", 16'(rd_ready), 16'd0);
        repeat (2) @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b0;
        rst = 1'b0;

        // Basic write then read of address 3.
        write_word(4'd3, 16'hABCD);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0);
        check_eq("t1_rd_ready", 16'(rd_ready), 16'd1);
        check_eq("t1_rd_index", mem_index, 16'd6);
        check_eq("t1_rd_valid_early", 16'(rd_data_valid), 16'd0);
        idle();
        check_eq("t1_rd_valid", 16'(rd_data_valid), 16'd1);
        check_eq("t1_rd_data", rd_data, 16'hABCD);
        idle();
        check_eq("t1_rd_valid_drop", 16'(rd_data_valid), 16'd0);
        check_eq("t1_rd_data_hold", rd_data, 16'hABCD);

        // Contention: grants alternate WR, RD, WR, RD.
        drive(1'b1, 4'd0, 16'h1111, 1'b1, 4'd5, 1'b0);
        check_eq("c1_wr_ready", 16'(wr_ready), 16'd1);
        check_eq("c1_rd_ready", 16'(rd_ready), 16'd0);
        check_eq("c1_index", mem_index, 16'd0);
        drive(1'b1, 4'd1, 16'h2222, 1'b1, 4'd5, 1'b0);
        check_eq("c2_wr_ready", 16'(wr_ready), 16'd0);
        check_eq("c2_rd_ready", 16'(rd_ready), 16'd1);
        check_eq("c2_index", mem_index, 16'd10);
        check_eq("c2_mem_wr_en", 16'(mem_wr_en), 16'd0);
        drive(1'b1, 4'd1, 16'h2222, 1'b1, 4'd5, 1'b0);
        check_eq("c3_wr_ready", 16'(wr_ready), 16'd1);
        check_eq("c3_rd_ready", 16'(rd_ready), 16'd0);
        check_eq("c3_index", mem_index, 16'd2);
        check_eq("c3_rd_valid", 16'(rd_data_valid), 16'd1);
        check_eq("c3_rd_data", rd_data, 16'hAAAB);
        drive(1'b1, 4'd0, 16'h3333, 1'b1, 4'd5, 1'b0);
        check_eq("c4_wr_ready", 16'(wr_ready), 16'd0);
        check_eq("c4_rd_ready", 16'(rd_ready), 16'd1);
        check_eq("c4_rd_valid", 16'(rd_data_valid), 16'd0);
        drive(1'b1, 4'd0, 16'h3333, 1'b0, 4'd0, 1'b0);
        check_eq("c5_wr_ready", 16'(wr_ready), 16'd1);
        check_eq("c5_data_in", mem_data_in, 16'h3333);
        check_eq("c5_rd_valid", 16'(rd_data_valid), 16'd1);
        check_eq("c5_rd_data", rd_data, 16'hAAAB);
        read_word(4'd0, 16'h3333);
        read_word(4'd1, 16'h2222);

        // Top word lands in bytes 30/31.
        write_word(4'd15, 16'h1234);
        idle();
        check_eq("t3_byte30", 16'(bank[30]), 16'h0012);
        check_eq("t3_byte31", 16'(bank[31]), 16'h0034);
        read_word(4'd15, 16'h1234);

        // Fill, then full clear sweep with requests held and a stray clr_start.
        for (int n = 0; n < 16; n++) write_word(4'(n), 16'(16'h5A01 + n));
        read_word(4'd9, 16'h5A0A);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);
        check_eq("s_start_wr_en", 16'(mem_wr_en), 16'd0);
        check_eq("s_start_busy", 16'(clr_busy), 16'd0);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'd2, 16'hFFFF, 1'b1, 4'd4, (k == 5));
            check_eq("s_busy", 16'(clr_busy), 16'd1);
            check_eq("s_wr_en", 16'(mem_wr_en), 16'd1);
            check_eq("s_index", mem_index, 16'(2 * k));
            check_eq("s_data_in", mem_data_in, 16'h0000);
            check_eq("s_wr_ready", 16'(wr_ready), 16'd0);
            check_eq("s_rd_ready", 16'(rd_ready), 16'd0);
            check_eq("s_done_early", 16'(clr_done), 16'd0);
        end
        idle();
        check_eq("s_busy_end", 16'(clr_busy), 16'd0);
        check_eq("s_done", 16'(clr_done), 16'd1);
        idle();
        check_eq("s_done_once", 16'(clr_done), 16'd0);
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'(k), 1'b0);
            check_eq("s_b2b_rd_ready", 16'(rd_ready), 16'd1);
            if (k > 0) begin
                check_eq("s_b2b_valid", 16'(rd_data_valid), 16'd1);
                check_eq("s_b2b_zero", rd_data, 16'h0000);
            end
        end
        idle();
        check_eq("s_b2b_valid_last", 16'(rd_data_valid), 16'd1);
        check_eq("s_b2b_zero_last", rd_data, 16'h0000);
        idle();
        check_eq("s_b2b_valid_drop", 16'(rd_data_valid), 16'd0);

        // clr_start wins over a simultaneous write; the held write follows the sweep.
        drive(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 1'b1);
        check_eq("h_wr_ready", 16'(wr_ready), 16'd0);
        check_eq("h_wr_en", 16'(mem_wr_en), 16'd0);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 1'b0);
            check_eq("h_wait_ready", 16'(wr_ready), 16'd0);
        end
        drive(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 1'b0);
        check_eq("h_grant", 16'(wr_ready), 16'd1);
        check_eq("h_done", 16'(clr_done), 16'd1);
        check_eq("h_index", mem_index, 16'd14);
        check_eq("h_data_in", mem_data_in, 16'hBEEF);
        read_word(4'd7, 16'hBEEF);

        // Reset during sweep cycle 7 aborts the clear.
        for (int n = 0; n < 16; n++) write_word(4'(n), 16'(16'hC000 + n));
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            idle();
            check_eq("a_index", mem_index, 16'(2 * k));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("a_busy", 16'(clr_busy), 16'd0);
        check_eq("a_wr_en", 16'(mem_wr_en), 16'd0);
        check_eq("a_rd_data", rd_data, 16'h0000);
        check_eq("a_rd_valid", 16'(rd_data_valid), 16'd0);
        check_eq("a_done", 16'(clr_done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check_eq("a_done_after", 16'(clr_done), 16'd0);
        check_eq("a_busy_after", 16'(clr_busy), 16'd0);
        for (int n = 0; n < 16; n++)
            read_word(4'(n), (n < 7) ? 16'h0000 : 16'(16'hC000 + n));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
